// File: rtl/rtype_fetch_seq_pkg.sv
// rtl/rtype_fetch_seq_pkg.sv - shared opcode constants, FSM states and decode record
package rtype_fetch_seq_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_LD   = 3'd2,
    S_ID   = 3'd3,
    S_RR   = 3'd4,
    S_EX   = 3'd5,
    S_WB   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic       reg_write;
  } dec_t;

endpackage

// File: rtl/rtype_decode.sv
// rtl/rtype_decode.sv - combinational R-type field extraction and legality check
module rtype_decode
  import rtype_fetch_seq_pkg::*;
(
  input  logic [31:0] i_ir,
  output dec_t        o_dec,
  output logic        o_legal
);

  logic [6:0] w_opcode;
  logic [6:0] w_funct7;

  assign w_opcode = i_ir[6:0];
  assign w_funct7 = i_ir[31:25];
  assign o_legal  = (w_opcode == OPC_RTYPE) &&
                    ((w_funct7 == F7_BASE) || (w_funct7 == F7_ALT));

  always_comb begin
    o_dec.rs1       = i_ir[19:15];
    o_dec.rs2       = i_ir[24:20];
    o_dec.rd        = i_ir[11:7];
    o_dec.alu_op    = {i_ir[30], i_ir[14:12]};
    // writes to x0 are discarded, so they never request write-back
    o_dec.reg_write = o_legal && (i_ir[11:7] != 5'd0);
  end

endmodule

// File: rtl/rtype_fetch_seq.sv
// rtl/rtype_fetch_seq.sv - six-phase fetch/decode sequencer driving the regfile/ALU datapath
module rtype_fetch_seq
  import rtype_fetch_seq_pkg::*;
#(
  parameter int          IM_AW    = 6,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  output logic [IM_AW-1:0] IM_Addr,
  input  logic [31:0]      IM_Data,
  output logic [4:0]       R_Addr_A,
  output logic [4:0]       R_Addr_B,
  output logic [4:0]       W_Addr,
  output logic [3:0]       ALU_OP,
  output logic             Reg_Write,
  output logic             en_RR,
  output logic             en_F,
  output logic             en_WB,
  output logic [31:0]      PC,
  output logic             busy,
  output logic             illegal
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  dec_t        r_dec;
  logic        r_illegal;
  dec_t        w_dec;
  logic        w_legal;

  rtype_decode u_decode (
    .i_ir    (r_ir),
    .o_dec   (w_dec),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_dec     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_LD: r_ir <= IM_Data;
        S_ID: begin
          r_dec <= w_dec;
          if (!w_legal) r_illegal <= 1'b1;
        end
        S_WB: r_pc <= r_pc + 32'd4;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    en_RR  = 1'b0;
    en_F   = 1'b0;
    en_WB  = 1'b0;
    busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (run || step) w_next = S_IF;
      end
      S_IF: w_next = S_LD;
      S_LD: w_next = S_ID;
      S_ID: w_next = w_legal ? S_RR : S_HALT;
      S_RR: begin
        en_RR  = 1'b1;
        w_next = S_EX;
      end
      S_EX: begin
        en_F   = 1'b1;
        w_next = S_WB;
      end
      S_WB: begin
        en_WB  = r_dec.reg_write;
        w_next = run ? S_IF : S_IDLE;
      end
      S_HALT: busy = 1'b0;
      default: w_next = S_IDLE;
    endcase
  end

  assign IM_Addr   = r_pc[IM_AW+1:2];
  assign PC        = r_pc;
  assign R_Addr_A  = r_dec.rs1;
  assign R_Addr_B  = r_dec.rs2;
  assign W_Addr    = r_dec.rd;
  assign ALU_OP    = r_dec.alu_op;
  assign Reg_Write = r_dec.reg_write;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_rtype_fetch_seq.sv
// tb/tb_rtype_fetch_seq.sv - directed table-driven bench for rtype_fetch_seq
module tb_rtype_fetch_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, step;
  logic [5:0]  im_addr;
  logic [31:0] im_data;
  logic [4:0]  ra, rb, wa;
  logic [3:0]  aop;
  logic        rw, e_rr, e_f, e_wb, busy, ill;
  logic [31:0] pc;

  logic        rst2, run2, step2;
  logic [1:0]  im_addr2;
  logic [31:0] im_data2;
  logic [4:0]  ra2, rb2, wa2;
  logic [3:0]  aop2;
  logic        rw2, e_rr2, e_f2, e_wb2, busy2, ill2;
  logic [31:0] pc2;

  logic [31:0] rom  [64];
  logic [31:0] rom2 [4];

  always @(posedge clk) im_data  <= rom[im_addr];
  always @(posedge clk) im_data2 <= rom2[im_addr2];

  rtype_fetch_seq #(.IM_AW(6), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .IM_Addr(im_addr), .IM_Data(im_data),
    .R_Addr_A(ra), .R_Addr_B(rb), .W_Addr(wa), .ALU_OP(aop), .Reg_Write(rw),
    .en_RR(e_rr), .en_F(e_f), .en_WB(e_wb), .PC(pc), .busy(busy), .illegal(ill)
  );

  rtype_fetch_seq #(.IM_AW(2), .RESET_PC(32'd0)) dut2 (
    .clk(clk), .rst(rst2), .run(run2), .step(step2), .IM_Addr(im_addr2), .IM_Data(im_data2),
    .R_Addr_A(ra2), .R_Addr_B(rb2), .W_Addr(wa2), .ALU_OP(aop2), .Reg_Write(rw2),
    .en_RR(e_rr2), .en_F(e_f2), .en_WB(e_wb2), .PC(pc2), .busy(busy2), .illegal(ill2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        wr;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [5:0] p_rr, p_f, p_wb;
    int multi, n_rr, n_f, n_wb, stray;

    rst = 1'b1; run = 1'b0; step = 1'b0;
    rst2 = 1'b1; run2 = 1'b0; step2 = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0033;
    for (int i = 0; i < 4; i++) rom2[i] = 32'h0020_81B3;

    vt[0] = '{32'h0020_81B3, 5'd1,  5'd2,  5'd3,  4'b0000, 1'b1};
    vt[1] = '{32'h4073_02B3, 5'd6,  5'd7,  5'd5,  4'b1000, 1'b1};
    vt[2] = '{32'h0020_8033, 5'd1,  5'd2,  5'd0,  4'b0000, 1'b0};
    vt[3] = '{32'h00C5_C533, 5'd11, 5'd12, 5'd10, 4'b0100, 1'b1};
    vt[4] = '{32'h41DF_5FB3, 5'd30, 5'd29, 5'd31, 4'b1101, 1'b1};
    for (int i = 0; i < 5; i++) rom[i] = vt[i].instr;

    repeat (2) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("reset_pc", pc, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_illegal", {31'd0, ill}, 32'd0);
    chk("reset_dec", {ra, rb, wa, aop, rw}, 32'd0);
    chk("reset_strobes", {e_rr, e_f, e_wb}, 32'd0);

    // single-step each table entry
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      p_rr = '0; p_f = '0; p_wb = '0; multi = 0;
      for (int c = 1; c <= 6; c++) begin
        if (c > 1) @(negedge clk);
        p_rr[c-1] = e_rr; p_f[c-1] = e_f; p_wb[c-1] = e_wb;
        if ((e_rr + e_f + e_wb) > 1) multi++;
        if (c == 1) begin
          chk($sformatf("v%0d_im_addr", i), im_addr, i);
          chk($sformatf("v%0d_busy", i), busy, 1);
        end
        if (c == 4) chk($sformatf("v%0d_dec", i), {ra, rb, wa, aop, rw},
                        {vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].op, vt[i].wr});
        if (c == 6) chk($sformatf("v%0d_dec_held", i), {ra, rb, wa, aop, rw},
                        {vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].op, vt[i].wr});
      end
      chk($sformatf("v%0d_en_rr", i), p_rr, 6'b001000);
      chk($sformatf("v%0d_en_f", i), p_f, 6'b010000);
      chk($sformatf("v%0d_en_wb", i), p_wb, vt[i].wr ? 6'b100000 : 6'b000000);
      chk($sformatf("v%0d_onehot", i), multi, 0);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), busy, 0);
      chk($sformatf("v%0d_pc", i), pc, 4 * (i + 1));
    end

    // asynchronous reset while in EX
    rom[5] = vt[0].instr;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    repeat (4) @(negedge clk);
    chk("midex_en_f", e_f, 1);
    #1 rst = 1'b1;
    #1;
    chk("midex_async_strobes", {e_rr, e_f, e_wb}, 0);
    chk("midex_async_pc", pc, 32'd0);
    chk("midex_async_dec", {ra, rb, wa, aop, rw, busy}, 0);
    @(negedge clk) rst = 1'b0;
    n_wb = 0;
    repeat (4) begin
      @(negedge clk);
      n_wb += e_wb;
    end
    chk("midex_no_wb", n_wb, 0);
    chk("midex_idle", busy, 0);

    // run+step together, back-to-back issue, then an illegal word halts
    rom[0] = 32'h0020_81B3; rom[1] = 32'h4073_02B3; rom[2] = 32'hFFFF_FFFF;
    @(negedge clk) begin run = 1'b1; step = 1'b1; end
    @(negedge clk) step = 1'b0;
    n_rr = 0; n_f = 0; n_wb = 0; stray = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 20 || c == 30) step = 1'b1;
      if (c == 21 || c == 31) step = 1'b0;
      if (c <= 12) begin
        n_rr += e_rr; n_f += e_f; n_wb += e_wb;
      end else stray += e_rr + e_f + e_wb;
      if (c == 7) begin
        chk("run_im_addr1", im_addr, 1);
        chk("run_busy_nogap", busy, 1);
      end
      if (c == 10) chk("run_sub_dec", {ra, rb, wa, aop}, {5'd6, 5'd7, 5'd5, 4'b1000});
      if (c == 13) chk("run_im_addr2", im_addr, 2);
      if (c == 16) begin
        chk("halt_illegal", ill, 1);
        chk("halt_busy", busy, 0);
        chk("halt_pc", pc, 32'd8);
        chk("halt_reg_write", rw, 0);
      end
    end
    chk("run_rr_count", n_rr, 2);
    chk("run_f_count", n_f, 2);
    chk("run_wb_count", n_wb, 2);
    chk("halt_no_strobes", stray, 0);
    chk("halt_pc_held", pc, 32'd8);
    chk("halt_sticky", ill, 1);
    run = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst_clears_illegal", ill, 0);
    chk("rst_pc", pc, 32'd0);

    // dropping run mid-instruction finishes it and returns to IDLE
    @(negedge clk) run = 1'b1;
    @(negedge clk);
    @(negedge clk) run = 1'b0;
    repeat (4) @(negedge clk);
    chk("rundrop_wb", e_wb, 1);
    @(negedge clk);
    chk("rundrop_idle", busy, 0);
    chk("rundrop_pc", pc, 32'd4);

    // narrow ROM: IM_Addr wraps while PC keeps counting
    @(negedge clk) run2 = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if ((c - 1) % 6 == 0) chk($sformatf("wrap_im_addr_c%0d", c), im_addr2, ((c - 1) / 6) % 4);
      if (c == 25) chk("wrap_pc", pc2, 32'd16);
    end
    run2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
